game: RTL and testbench

GAME -- requirements
Module: game

---
 rtl/game_pkg.sv | 38 +++
 rtl/game_debounce.sv | 48 ++++
 rtl/game.sv | 94 +++++++++
 tb/tb_game.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants for the BCD up/down counter display
// Purpose : digit count and active-low 7-segment lookup for the game block.
//           Segment patterns are in g..a bit order; a 0 bit lights the segment.
// Ports   : none (package).
package game_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Non-BCD codes cannot occur in the counter; they blank the digit.
   function automatic logic [6:0] bcdToSeg(input logic [3:0] digit);
      case (digit)
         4'd0:    bcdToSeg = SEG_0;
         4'd1:    bcdToSeg = SEG_1;
         4'd2:    bcdToSeg = SEG_2;
         4'd3:    bcdToSeg = SEG_3;
         4'd4:    bcdToSeg = SEG_4;
         4'd5:    bcdToSeg = SEG_5;
         4'd6:    bcdToSeg = SEG_6;
         4'd7:    bcdToSeg = SEG_7;
         4'd8:    bcdToSeg = SEG_8;
         4'd9:    bcdToSeg = SEG_9;
         default: bcdToSeg = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/game_debounce.sv
// rtl/game_debounce.sv - pushbutton synchronizer, debouncer and press detector
// Purpose : brings a raw button into the clock domain through two flops, then
//           only accepts a new level after DEBOUNCE_CYCLES consecutive samples
//           that disagree with the current debounced level.
// Ports   : clk   - system clock
//           rst   - asynchronous active-high reset
//           btn   - raw pushbutton, asynchronous to clk
//           press - one-cycle pulse when the debounced level rises
module game_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       syncFf;
   logic             level;
   logic [CNT_W-1:0] stableCnt;

   // stableCnt counts consecutive samples differing from level; any sample
   // matching level restarts the count, so bounce never reaches LAST_COUNT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncFf    <= 2'b00;
         level     <= 1'b0;
         stableCnt <= '0;
         press     <= 1'b0;
      end else begin
         syncFf <= {syncFf[0], btn};
         press  <= 1'b0;
         if (syncFf[1] == level) begin
            stableCnt <= '0;
         end else if (stableCnt == LAST_COUNT) begin
            level     <= syncFf[1];
            stableCnt <= '0;
            press     <= syncFf[1];
         end else begin
            stableCnt <= stableCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/game.sv
// rtl/game.sv - 4-digit BCD up/down counter on a multiplexed 7-segment display
// Purpose : counts debounced up/down presses in decimal (0000..9999, wrapping)
//           and scans the four digits onto a common-anode display.
// Ports   : Clk100Mhz - system clock
//           btnS      - asynchronous active-high reset
//           btnU/btnD - raw up/down pushbuttons
//           seg       - active-low segments {dp, g..a}
//           an        - active-low digit enables, an[0] = units digit
module game
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REFRESH_BITS    = 17
) (
   input  logic       Clk100Mhz,
   input  logic       btnS,
   input  logic       btnU,
   input  logic       btnD,
   output logic [7:0] seg,
   output logic [3:0] an
);

   logic                             upPress;
   logic                             downPress;
   logic [NUM_DIGITS-1:0][3:0]       bcd;
   logic [NUM_DIGITS-1:0][3:0]       nextBcd;
   logic                             carry;
   logic [REFRESH_BITS-1:0]          refresh;
   logic [1:0]                       digitSel;

   game_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upDebounce (
      .clk   (Clk100Mhz),
      .rst   (btnS),
      .btn   (btnU),
      .press (upPress)
   );

   game_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downDebounce (
      .clk   (Clk100Mhz),
      .rst   (btnS),
      .btn   (btnD),
      .press (downPress)
   );

   // Ripple the decimal carry/borrow from the units digit upward; a digit
   // only changes while a carry is still pending. Simultaneous presses cancel.
   always_comb begin
      nextBcd = bcd;
      carry   = 1'b0;
      if (upPress && !downPress) begin
         carry = 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
               if (bcd[i] == 4'd9) begin
                  nextBcd[i] = 4'd0;
               end else begin
                  nextBcd[i] = bcd[i] + 4'd1;
                  carry      = 1'b0;
               end
            end
         end
      end else if (downPress && !upPress) begin
         carry = 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
               if (bcd[i] == 4'd0) begin
                  nextBcd[i] = 4'd9;
               end else begin
                  nextBcd[i] = bcd[i] - 4'd1;
                  carry      = 1'b0;
               end
            end
         end
      end
   end

   assign digitSel = refresh[REFRESH_BITS-1 -: 2];

   always_ff @(posedge Clk100Mhz or posedge btnS) begin
      if (btnS) begin
         bcd     <= '0;
         refresh <= '0;
         an      <= 4'b1110;
         seg     <= {1'b1, SEG_0};
      end else begin
         bcd     <= nextBcd;
         refresh <= refresh + REFRESH_BITS'(1);
         // Registered so the enable and pattern switch on the same edge.
         an      <= ~(4'b0001 << digitSel);
         seg     <= {1'b1, bcdToSeg(bcd[digitSel])};
      end
   end

endmodule

// File: tb/tb_game.sv
// tb/tb_game.sv - self-checking bench for the game counter/display
module tb_game;

   logic       clk = 1'b0;
   logic       btnS;
   logic       btnU;
   logic       btnD;
   logic [7:0] seg;
   logic [3:0] an;

   int assertions = 0;
   int failures   = 0;
   int model      = 0;
   int expQ[$];

   game #(.DEBOUNCE_CYCLES(4), .REFRESH_BITS(4)) dut (
      .Clk100Mhz (clk),
      .btnS      (btnS),
      .btnU      (btnU),
      .btnD      (btnD),
      .seg       (seg),
      .an        (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertions++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int segToDigit(input logic [6:0] s);
      case (s)
         7'b1000000: return 0;
         7'b1111001: return 1;
         7'b0100100: return 2;
         7'b0110000: return 3;
         7'b0011001: return 4;
         7'b0010010: return 5;
         7'b0000010: return 6;
         7'b1111000: return 7;
         7'b0000000: return 8;
         7'b0010000: return 9;
         default:    return 15;
      endcase
   endfunction

   task automatic pressUp();
      btnU = 1'b1;
      repeat (20) @(negedge clk);
      btnU = 1'b0;
      repeat (20) @(negedge clk);
      model = (model + 1) % 10000;
   endtask

   task automatic pressDown();
      btnD = 1'b1;
      repeat (20) @(negedge clk);
      btnD = 1'b0;
      repeat (20) @(negedge clk);
      model = (model + 9999) % 10000;
   endtask

   task automatic pressBoth();
      btnU = 1'b1;
      btnD = 1'b1;
      repeat (20) @(negedge clk);
      btnU = 1'b0;
      btnD = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic expectNow();
      expQ.push_back(model);
   endtask

   // Watches a bounded window of the scan, decodes each digit from the
   // segment pattern and compares the assembled value with the scoreboard.
   task automatic checkDisplay(input string tag, output logic [7:0] unitsSeg);
      int   digits[4];
      bit   seen[4];
      bit   dpOff;
      int   idx;
      int   value;
      int   expVal;
      dpOff    = 1'b1;
      unitsSeg = 8'h00;
      for (int i = 0; i < 4; i++) begin
         digits[i] = 15;
         seen[i]   = 1'b0;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         if (idx >= 0) begin
            digits[idx] = segToDigit(seg[6:0]);
            seen[idx]   = 1'b1;
            if (idx == 0) unitsSeg = seg;
            if (seg[7] !== 1'b1) dpOff = 1'b0;
         end
      end
      value = digits[3] * 1000 + digits[2] * 100 + digits[1] * 10 + digits[0];
      check({tag, "_all_digits_seen"}, {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'hF);
      check({tag, "_dp_off"}, {31'd0, dpOff}, 32'd1);
      if (expQ.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         expVal = expQ.pop_front();
         check({tag, "_value"}, value, expVal);
      end
   endtask

   initial begin
      logic [7:0] u;
      logic [3:0] prevAn;
      int         runLen;
      bit         firstRun;

      btnS = 1'b1;
      btnU = 1'b0;
      btnD = 1'b0;
      repeat (3) @(negedge clk);
      check("in_reset_an", an, 4'b1110);
      check("in_reset_seg", seg, 8'b11000000);
      btnS  = 1'b0;
      model = 0;
      @(negedge clk);
      check("post_reset_an", an, 4'b1110);
      check("post_reset_seg", seg, 8'b11000000);
      expectNow();
      checkDisplay("reset_value", u);

      pressDown();
      expectNow();
      checkDisplay("wrap_down_9999", u);
      pressUp();
      expectNow();
      checkDisplay("wrap_up_0000", u);

      repeat (3) pressUp();
      expectNow();
      checkDisplay("three_up", u);
      check("units_seg_three", u, 8'b10110000);

      for (int i = 0; i < 30; i++) begin
         btnU = ~btnU;
         @(negedge clk);
      end
      btnU = 1'b0;
      repeat (20) @(negedge clk);
      expectNow();
      checkDisplay("bounce_ignored", u);

      repeat (6) pressUp();
      expectNow();
      checkDisplay("reach_0009", u);
      pressUp();
      expectNow();
      checkDisplay("carry_0010", u);
      repeat (90) pressUp();
      expectNow();
      checkDisplay("reach_0100", u);
      pressDown();
      expectNow();
      checkDisplay("borrow_0099", u);
      pressBoth();
      expectNow();
      checkDisplay("both_unchanged", u);

      btnU = 1'b1;
      repeat (4) @(negedge clk);
      btnS = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_press_reset_an", an, 4'b1110);
      check("mid_press_reset_seg", seg, 8'b11000000);
      btnS  = 1'b0;
      model = 0;
      repeat (20) @(negedge clk);
      btnU = 1'b0;
      repeat (20) @(negedge clk);
      model = 1;
      expectNow();
      checkDisplay("held_through_reset", u);

      prevAn   = an;
      runLen   = 0;
      firstRun = 1'b1;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         check("an_one_hot", $countones(~an), 1);
         if (an !== prevAn) begin
            check("an_order", an, {prevAn[2:0], prevAn[3]});
            if (!firstRun) check("an_dwell", runLen, 4);
            firstRun = 1'b0;
            runLen   = 1;
            prevAn   = an;
         end else begin
            runLen++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
